// File: rtl/overlay_text_renderer.sv
// 32x28 character-cell text overlay for a 256x224 framebuffer.
// Pipeline: coordinates -> cell RAM -> external font ROM -> palette -> BGR5 pixel.
module overlay_text_renderer #(
    parameter int unsigned BLINK_BIT = 5
) (
    input  logic        clk_vga,
    input  logic        resetn,
    input  logic        osd_enable,
    input  logic [7:0]  overlay_x,
    input  logic [7:0]  overlay_y,
    output logic [15:0] overlay_color,
    input  logic        wr_en,
    input  logic [9:0]  wr_addr,
    input  logic [15:0] wr_data,
    input  logic        pal_we,
    input  logic [3:0]  pal_addr,
    input  logic [14:0] pal_data,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data
);

    localparam int unsigned COORD_W    = 8;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned CELL_W     = 16;
    localparam int unsigned COLOR_W    = 15;
    localparam int unsigned PAL_N      = 16;
    localparam int unsigned CELL_COUNT = 896;
    localparam int unsigned Y_LIMIT    = 224;
    localparam int unsigned FRAME_W    = 8;

    localparam logic [PAL_N-1:0][COLOR_W-1:0] PAL_RESET = {
        {11{15'h0000}}, 15'h7C00, 15'h03E0, 15'h001F, 15'h7FFF, 15'h0000
    };

    typedef struct packed {
        logic       blink;
        logic [2:0] bg;
        logic [3:0] fg;
        logic [7:0] code;
    } cell_t;

    typedef struct packed {
        logic       blink;
        logic [2:0] bg;
        logic [3:0] fg;
    } attr_t;

    // S0
    logic [COORD_W-1:0] x0_q, x0_d, y0_q, y0_d;
    logic               en0_q, en0_d;
    logic               prev_zero_q, prev_zero_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    // S1
    logic [2:0]         x1_q, x1_d, y1_q, y1_d;
    logic               en1_q, en1_d, ph1_q, ph1_d;
    // S2
    logic [10:0]        font_addr_q, font_addr_d;
    attr_t              attr2_q, attr2_d;
    logic [2:0]         x2_q, x2_d;
    logic               en2_q, en2_d, ph2_q, ph2_d;
    // S3
    attr_t              attr3_q, attr3_d;
    logic [2:0]         x3_q, x3_d;
    logic               en3_q, en3_d, ph3_q, ph3_d;
    // S4
    logic [15:0]        color_q, color_d;

    logic [PAL_N-1:0][COLOR_W-1:0] pal_q, pal_d;

    logic [CELL_W-1:0]  cell_mem [CELL_COUNT];
    logic [CELL_W-1:0]  cell_rd_q;
    logic [ADDR_W-1:0]  rd_addr;
    cell_t              rd_cell;
    logic               at_origin;
    logic               pix_bit;
    logic [COLOR_W-1:0] fg_col, bg_col;

    // Cell RAM: registered read returns pre-write contents on a same-address collision.
    always_ff @(posedge clk_vga) begin
        if (wr_en && (wr_addr < ADDR_W'(CELL_COUNT))) begin
            cell_mem[wr_addr] <= wr_data;
        end
        cell_rd_q <= cell_mem[rd_addr];
    end

    always_comb begin
        x0_d        = overlay_x;
        y0_d        = overlay_y;
        en0_d       = osd_enable;
        at_origin   = (overlay_x == '0) && (overlay_y == '0);
        prev_zero_d = at_origin;
        frame_d     = frame_q;
        if (at_origin && !prev_zero_q) begin
            frame_d = frame_q + FRAME_W'(1);
        end

        // Rows past the visible area fold onto cell 0 instead of the unused RAM tail.
        rd_addr = (y0_q < COORD_W'(Y_LIMIT)) ? {y0_q[7:3], x0_q[7:3]} : '0;
        x1_d    = x0_q[2:0];
        y1_d    = y0_q[2:0];
        en1_d   = en0_q;
        ph1_d   = frame_q[BLINK_BIT];

        rd_cell     = cell_t'(cell_rd_q);
        font_addr_d = {rd_cell.code, y1_q};
        attr2_d     = '{blink: rd_cell.blink, bg: rd_cell.bg, fg: rd_cell.fg};
        x2_d        = x1_q;
        en2_d       = en1_q;
        ph2_d       = ph1_q;

        attr3_d = attr2_q;
        x3_d    = x2_q;
        en3_d   = en2_q;
        ph3_d   = ph2_q;

        pal_d = pal_q;
        if (pal_we) begin
            pal_d[pal_addr] = pal_data;
        end

        // Look up through pal_d so a write in this cycle already colours this pixel.
        pix_bit = font_data[3'(3'd7 - x3_q)];
        fg_col  = pal_d[attr3_q.fg];
        bg_col  = pal_d[{1'b0, attr3_q.bg}];
        if (attr3_q.blink && ph3_q) begin
            fg_col = bg_col;
        end
        color_d = en3_q ? {1'b0, (pix_bit ? fg_col : bg_col)} : '0;
    end

    always_ff @(posedge clk_vga) begin
        if (!resetn) begin
            x0_q        <= '0;
            y0_q        <= '0;
            en0_q       <= 1'b0;
            prev_zero_q <= 1'b1;
            frame_q     <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            en1_q       <= 1'b0;
            ph1_q       <= 1'b0;
            font_addr_q <= '0;
            attr2_q     <= '0;
            x2_q        <= '0;
            en2_q       <= 1'b0;
            ph2_q       <= 1'b0;
            attr3_q     <= '0;
            x3_q        <= '0;
            en3_q       <= 1'b0;
            ph3_q       <= 1'b0;
            color_q     <= '0;
            pal_q       <= PAL_RESET;
        end else begin
            x0_q        <= x0_d;
            y0_q        <= y0_d;
            en0_q       <= en0_d;
            prev_zero_q <= prev_zero_d;
            frame_q     <= frame_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            en1_q       <= en1_d;
            ph1_q       <= ph1_d;
            font_addr_q <= font_addr_d;
            attr2_q     <= attr2_d;
            x2_q        <= x2_d;
            en2_q       <= en2_d;
            ph2_q       <= ph2_d;
            attr3_q     <= attr3_d;
            x3_q        <= x3_d;
            en3_q       <= en3_d;
            ph3_q       <= ph3_d;
            color_q     <= color_d;
            pal_q       <= pal_d;
        end
    end

    assign overlay_color = color_q;
    assign font_addr     = font_addr_q;

endmodule
